// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flexible FIFO family.
// Used by fifo_flex, its flag decoder and the property checker.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(
    input int depth,
    input int afull,
    input int aempty
  );
    return depth >= 2 &&
           afull >= 1 && afull <= depth &&
           aempty >= 0 && aempty <= depth - 1;
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Handshake and status bundle of fifo_flex.
// master drives requests, slave is the FIFO.
interface fifo_flex_if #(
  parameter int width   = 8,
  parameter int count_w = 4
) ();

  logic               fifo_clear;
  logic               fifo_write;
  logic [width-1:0]   fifo_data_in;
  logic               fifo_full;
  logic               fifo_almost_full;
  logic               fifo_read;
  logic [width-1:0]   fifo_data_out;
  logic               fifo_empty;
  logic               fifo_almost_empty;
  logic [count_w-1:0] fifo_count;
  logic               fifo_overflow;
  logic               fifo_underflow;

  modport master (
    output fifo_clear, fifo_write,
    output fifo_data_in, fifo_read,
    input  fifo_full, fifo_almost_full,
    input  fifo_data_out, fifo_empty,
    input  fifo_almost_empty, fifo_count,
    input  fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_clear, fifo_write,
    input  fifo_data_in, fifo_read,
    output fifo_full, fifo_almost_full,
    output fifo_data_out, fifo_empty,
    output fifo_almost_empty, fifo_count,
    output fifo_overflow, fifo_underflow
  );

endinterface

// File: rtl/fifo_flag_gen.sv
// Occupancy flag decode from the registered fill count.
// Kept separate so checkers can bind to the same decode.
module fifo_flag_gen
  import fifo_pkg::*;
#(
  parameter  int depth         = 8,
  parameter  int afull_thresh  = 6,
  parameter  int aempty_thresh = 2,
  localparam int CW            = cnt_w(depth)
) (
  input  logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam logic [CW-1:0] DEPTH  = CW'(depth);
  localparam logic [CW-1:0] AFULL  = CW'(afull_thresh);
  localparam logic [CW-1:0] AEMPTY = CW'(aempty_thresh);

  assign full         = count == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = count >= AFULL;
  assign almost_empty = count <= AEMPTY;

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with fill count, threshold flags, sticky
// errors, synchronous flush and optional fall-through read.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int fifo_depth    = 8,
  parameter int fifo_width    = 8,
  parameter int fwft          = 0,
  parameter int afull_thresh  = fifo_depth - 2,
  parameter int aempty_thresh = 2
) (
  input logic        clk,
  input logic        rstn,
  fifo_flex_if.slave bus
);

  localparam int CW = cnt_w(fifo_depth);
  localparam int PW = $clog2(fifo_depth);
  localparam fifo_mode_e MODE =
    (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] LAST = PW'(fifo_depth - 1);

  if (!params_ok(fifo_depth, afull_thresh,
                 aempty_thresh)) begin : g_bad_params
    $fatal(1, "fifo_flex: illegal parameters");
  end

  logic [fifo_width-1:0] mem [fifo_depth];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic [fifo_width-1:0] dout_q;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic                  aempty;
  logic                  rd_ok;
  logic                  wr_ok;

  fifo_flag_gen #(
    .depth        (fifo_depth),
    .afull_thresh (afull_thresh),
    .aempty_thresh(aempty_thresh)
  ) u_flags (
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (afull),
    .almost_empty(aempty)
  );

  // A full FIFO still takes a write when a read frees a slot.
  assign rd_ok = bus.fifo_read && !empty;
  assign wr_ok = bus.fifo_write && (!full || rd_ok);

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ok && !bus.fifo_clear)
      mem[wr_ptr] <= bus.fifo_data_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout_q    <= '0;
    end else if (bus.fifo_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= nxt(wr_ptr);
      if (rd_ok)
        rd_ptr <= nxt(rd_ptr);
      if (wr_ok && !rd_ok)
        count <= count + 1'b1;
      else if (rd_ok && !wr_ok)
        count <= count - 1'b1;
      if (bus.fifo_write && !wr_ok)
        overflow <= 1'b1;
      if (bus.fifo_read && !rd_ok)
        underflow <= 1'b1;
      if (MODE == FIFO_STD && rd_ok)
        dout_q <= mem[rd_ptr];
    end
  end

  assign bus.fifo_data_out =
    (MODE == FIFO_FWFT) ? (empty ? '0 : mem[rd_ptr])
                        : dout_q;

  assign bus.fifo_full         = full;
  assign bus.fifo_almost_full  = afull;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_empty = aempty;
  assign bus.fifo_count        = count;
  assign bus.fifo_overflow     = overflow;
  assign bus.fifo_underflow    = underflow;

endmodule
